// File: rtl/mux_rr_stream.sv
// Stream selector: picks one of CH valid/ready channels per cycle, by fixed select or round-robin,
// and registers the chosen beat into a one-entry output stage.
module mux_rr_stream #(
   parameter int N     = 8,
   parameter int CH    = 8,
   parameter int SEL_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CH*N-1:0]   in_data,
   input  logic [CH-1:0]     in_valid,
   output logic [CH-1:0]     in_ready,
   input  logic              mode,
   input  logic [SEL_W-1:0]  sel,
   output logic [N-1:0]      out_data,
   output logic [SEL_W-1:0]  out_ch,
   output logic              out_valid,
   input  logic              out_ready
);

   logic              out_valid_q, out_valid_d;
   logic [N-1:0]      out_data_q,  out_data_d;
   logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
   logic [SEL_W-1:0]  ptr_q,       ptr_d;

   logic              can_load_s;
   logic              gnt_found_s;
   logic [SEL_W-1:0]  gnt_idx_s;
   logic [CH-1:0]     gnt_vec_s;
   logic [N-1:0]      gnt_data_s;
   logic [2*CH-1:0]   rot_valid_s;
   logic [SEL_W-1:0]  ptr_inc_s;
   logic              xfer_s;

   // Grant decision: fixed select or first valid channel at/after the pointer
   always_comb begin
      gnt_found_s = 1'b0;
      gnt_idx_s   = '0;
      // Doubled vector shifted by the pointer so bit i is channel (ptr+i) mod CH
      rot_valid_s = {in_valid, in_valid} >> ptr_q;
      if (mode == 1'b0) begin
         for (int k = 0; k < CH; k++) begin
            gnt_idx_s   = ((int'(sel) == k) && in_valid[k]) ? SEL_W'(k) : gnt_idx_s;
            gnt_found_s = gnt_found_s | ((int'(sel) == k) && in_valid[k]);
         end
      end else begin
         for (int i = 0; i < CH; i++) begin
            gnt_idx_s   = (!gnt_found_s && rot_valid_s[i])
                          ? SEL_W'(((int'(ptr_q) + i) >= CH) ? (int'(ptr_q) + i - CH) : (int'(ptr_q) + i))
                          : gnt_idx_s;
            gnt_found_s = gnt_found_s | rot_valid_s[i];
         end
      end
   end

   // One-hot grant vector and the granted channel's data
   always_comb begin
      gnt_vec_s  = '0;
      gnt_data_s = '0;
      for (int k = 0; k < CH; k++) begin
         gnt_vec_s[k] = gnt_found_s && (int'(gnt_idx_s) == k);
         gnt_data_s   = gnt_vec_s[k] ? in_data[k*N +: N] : gnt_data_s;
      end
   end

   assign can_load_s = !out_valid_q | out_ready;
   assign xfer_s     = gnt_found_s & can_load_s & rst_n;
   assign ptr_inc_s  = ((int'(gnt_idx_s) + 1) >= CH) ? '0 : SEL_W'(int'(gnt_idx_s) + 1);
   assign in_ready   = (rst_n & can_load_s) ? gnt_vec_s : '0;

   // Output stage and pointer next-state
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      ptr_d       = ptr_q;
      if (xfer_s) begin
         out_valid_d = 1'b1;
         out_data_d  = gnt_data_s;
         out_ch_d    = gnt_idx_s;
         ptr_d       = mode ? ptr_inc_s : ptr_q;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State registers, cleared asynchronously so a held beat is discarded on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Scoreboard bench for mux_rr_stream: a reference grant model predicts in_ready and queues
// expected beats, which are popped and compared whenever the consumer takes one.
module tb_mux_rr_stream;
   localparam int N     = 8;
   localparam int CH    = 8;
   localparam int SEL_W = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [CH*N-1:0]   in_data;
   logic [CH-1:0]     in_valid;
   logic [CH-1:0]     in_ready;
   logic              mode;
   logic [SEL_W-1:0]  sel;
   logic [N-1:0]      out_data;
   logic [SEL_W-1:0]  out_ch;
   logic              out_valid;
   logic              out_ready;

   typedef struct packed {
      logic [SEL_W-1:0] ch;
      logic [N-1:0]     data;
   } beat_t;

   beat_t sb_q[$];
   bit    m_valid;
   int    m_ptr;
   int    errors = 0;
   int    checks = 0;

   mux_rr_stream #(.N(N), .CH(CH), .SEL_W(SEL_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .sel(sel), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   function automatic int model_grant(input logic md, input int s, input logic [CH-1:0] v, input int p);
      int c;
      if (!md) begin
         if (s >= CH) return -1;
         return v[s] ? s : -1;
      end
      for (int i = 0; i < CH; i++) begin
         c = (p + i) % CH;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_ptr   = 0;
      sb_q.delete();
   endtask

   // One clock: predict, compare, update the model, then advance to the next falling edge
   task automatic step();
      logic [CH-1:0] exp_rdy;
      int            g;
      beat_t         b;
      #1;
      g = model_grant(mode, int'(sel), in_valid, m_ptr);
      exp_rdy = '0;
      if (g >= 0 && (!m_valid || out_ready)) exp_rdy[g] = 1'b1;
      checks++;
      if (out_valid !== m_valid) begin
         errors++; $display("FAIL sb_out_valid: got %b want %b at %0t", out_valid, m_valid, $time);
      end
      checks++;
      if (in_ready !== exp_rdy) begin
         errors++; $display("FAIL sb_in_ready: got %b want %b at %0t", in_ready, exp_rdy, $time);
      end
      if (m_valid && out_ready) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++; $display("FAIL sb_empty: got beat ch=%0d data=%h want none", out_ch, out_data);
         end else begin
            b = sb_q.pop_front();
            if ({out_ch, out_data} !== b) begin
               errors++;
               $display("FAIL sb_beat: got ch=%0d data=%h want ch=%0d data=%h at %0t",
                        out_ch, out_data, b.ch, b.data, $time);
            end
         end
      end
      if (exp_rdy != '0) begin
         b.ch   = SEL_W'(g);
         b.data = N'(8'h10 + g);
         sb_q.push_back(b);
         m_valid = 1'b1;
         if (mode) m_ptr = (g + 1) % CH;
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 4'd0) begin
         errors++; $display("FAIL reset_state: got v=%b d=%h ch=%0d want 0/00/0", out_valid, out_data, out_ch);
      end
      mode = 1'b1; in_valid = '1;
      step();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 4'd0 || in_ready !== 8'h00) begin
         errors++;
         $display("FAIL async_reset: got v=%b d=%h ch=%0d rdy=%b want 0/00/0/0", out_valid, out_data, out_ch, in_ready);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 8'h01) begin
         errors++; $display("FAIL reset_first_grant: got %b want 00000001", in_ready);
      end
      step();
   endtask

   task automatic test_fixed_select();
      mode = 1'b0; sel = 4'd5; in_valid = '1; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 8'h20) begin
         errors++; $display("FAIL fixed_ready: got %b want 00100000", in_ready);
      end
      step();
      checks++;
      if (out_data !== 8'h15 || out_ch !== 4'd5) begin
         errors++; $display("FAIL fixed_beat: got d=%h ch=%0d want 15/5", out_data, out_ch);
      end
      sel = 4'd9;
      #1;
      checks++;
      if (in_ready !== 8'h00) begin
         errors++; $display("FAIL sel_oob_ready: got %b want 0", in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL sel_oob_drain: got out_valid=%b want 0", out_valid);
      end
      step();
   endtask

   task automatic test_round_robin();
      int            order [8] = '{1, 2, 5, 7, 1, 2, 5, 7};
      logic [CH-1:0] exp;
      mode = 1'b1; in_valid = 8'b1010_0110; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp = '0;
         exp[order[i]] = 1'b1;
         #1;
         checks++;
         if (in_ready !== exp) begin
            errors++; $display("FAIL rr_order[%0d]: got %b want %b", i, in_ready, exp);
         end
         step();
         checks++;
         if (out_valid !== 1'b1 || out_ch !== SEL_W'(order[i])) begin
            errors++; $display("FAIL rr_out[%0d]: got v=%b ch=%0d want 1/%0d", i, out_valid, out_ch, order[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      mode = 1'b1; in_valid = 8'b0000_0110; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'h11 || in_ready !== 8'h00) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got v=%b d=%h rdy=%b want 1/11/0", i, out_valid, out_data, in_ready);
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 8'h04) begin
         errors++; $display("FAIL stall_release_ready: got %b want 00000100", in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h12) begin
         errors++; $display("FAIL stall_release_beat: got v=%b d=%h want 1/12", out_valid, out_data);
      end
      in_valid = '0;
      step();
      step();
   endtask

   task automatic test_wrap_mode();
      mode = 1'b1; in_valid = 8'h80; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 8'h80) begin
         errors++; $display("FAIL wrap_ch7: got %b want 10000000", in_ready);
      end
      step();
      mode = 1'b0; sel = 4'd7; in_valid = 8'h81;
      #1;
      checks++;
      if (in_ready !== 8'h80) begin
         errors++; $display("FAIL mode0_sel7: got %b want 10000000", in_ready);
      end
      step();
      mode = 1'b1;
      #1;
      checks++;
      if (in_ready !== 8'h01) begin
         errors++; $display("FAIL ptr_kept: got %b want 00000001", in_ready);
      end
      step();
      #1;
      checks++;
      if (in_ready !== 8'h80) begin
         errors++; $display("FAIL ptr_after_ch0: got %b want 10000000", in_ready);
      end
      step();
      in_valid = '0;
      step();
   endtask

   task automatic test_reset_stall();
      mode = 1'b1; in_valid = 8'h08; out_ready = 1'b1;
      step();
      in_valid = '0; out_ready = 1'b0;
      step();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 8'h00) begin
         errors++; $display("FAIL reset_stall: got v=%b rdy=%b want 0/0", out_valid, in_ready);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      repeat (3) step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL stale_beat: got out_valid=%b want 0", out_valid);
      end
   endtask

   initial begin
      rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b1;
      for (int k = 0; k < CH; k++) in_data[k*N +: N] = N'(8'h10 + k);
      model_reset();
      test_reset();
      test_fixed_select();
      test_round_robin();
      test_backpressure();
      test_wrap_mode();
      test_reset_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
